byte_lane_memory: RTL and testbench

BYTE_LANE_MEMORY -- requirements
Module: byte_lane_memory

---
 rtl/byte_lane_memory_pkg.sv | 27 ++
 rtl/byte_lane_ram.sv | 29 ++
 rtl/byte_lane_memory.sv | 174 +++++++++++++++++
 tb/tb_byte_lane_memory.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_lane_memory_pkg.sv
// Shared constants, types and byte-address arithmetic for the byte-lane memory.
package byte_lane_memory_pkg;

  localparam int unsigned LANES     = 4;
  localparam int unsigned STORE_BIT = 4;
  localparam int unsigned BE_MSB    = 3;
  localparam int unsigned CODE_W    = 5;

  // A 33-bit byte address split into word and lane; the carry bit keeps
  // wrapped addresses out of range instead of aliasing onto low memory.
  typedef struct packed {
    logic [30:0] word;
    logic [1:0]  lane;
  } byte_loc_t;

  typedef enum logic {
    SNOOP_IDLE,
    SNOOP_SCAN
  } snoop_state_e;

  function automatic byte_loc_t byte_loc(input logic [31:0] base, input logic [1:0] offset);
    logic [32:0] addr;
    addr = {1'b0, base} + 33'(offset);
    return byte_loc_t'(addr);
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// One byte lane: single write port, two synchronous read ports, read-before-write.
module byte_lane_ram #(
  parameter int unsigned DEPTH_WORDS = 16,
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re_a,
  input  logic [AW-1:0] raddr_a,
  output logic [7:0]    rdata_a,
  input  logic          re_b,
  input  logic [AW-1:0] raddr_b,
  output logic [7:0]    rdata_b
);

  logic [7:0] mem [DEPTH_WORDS];

  // Disabled reads return zero so the top can assemble lanes without masking.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_a <= re_a ? mem[raddr_a] : 8'h00;
    rdata_b <= re_b ? mem[raddr_b] : 8'h00;
  end

endmodule

// File: rtl/byte_lane_memory.sv
// Byte-addressable memory built from four byte lanes, with a request port and
// an independent display snoop port that scans the low SNOOP_BYTES bytes.
module byte_lane_memory
  import byte_lane_memory_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 16,
  parameter int unsigned SNOOP_BYTES = 32,
  localparam int unsigned IDX_W = (SNOOP_BYTES > 1) ? $clog2(SNOOP_BYTES) : 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CODE_W-1:0] memory_access_code,
  input  logic [31:0]       memory_address,
  input  logic [31:0]       data_to_store,
  output logic              rsp_valid,
  output logic [31:0]       writeback_register_data,
  output logic              addr_error,
  input  logic              snoop_start,
  output logic              snoop_busy,
  output logic              snoop_valid,
  output logic [IDX_W-1:0]  snoop_index,
  output logic [7:0]        snoop_byte
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic             accept;
  logic             is_store;
  logic [BE_MSB:0]  be;
  byte_loc_t        req_loc [LANES];
  logic [LANES-1:0] lane_en;
  logic [LANES-1:0] lane_ok;
  logic [LANES-1:0] lane_we;
  logic [LANES-1:0] lane_re;
  logic [AW-1:0]    lane_word [LANES];
  logic [7:0]       lane_wdata [LANES];
  logic [7:0]       rd_req [LANES];
  logic [7:0]       rd_snoop [LANES];
  logic             req_err;

  logic             rsp_load;
  logic [1:0]       rsp_shift;
  logic [31:0]      load_data;

  snoop_state_e     state;
  logic [IDX_W-1:0] ptr;
  byte_loc_t        snoop_loc;
  logic [LANES-1:0] snoop_re;
  logic [AW-1:0]    snoop_word;
  logic [7:0]       snoop_mux;

  assign req_ready = ~reset;
  assign accept    = req_valid & ~reset;
  assign is_store  = memory_access_code[STORE_BIT];
  assign be        = memory_access_code[BE_MSB:0];

  // Route each request byte (big-endian position i) to the lane it lands in.
  always_comb begin : lane_decode
    lane_en = '0;
    lane_ok = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_word[l]  = '0;
      lane_wdata[l] = '0;
    end
    for (int i = 0; i < LANES; i++) begin
      req_loc[i] = byte_loc(memory_address, 2'(i));
      lane_en[req_loc[i].lane]    = be[BE_MSB - i];
      lane_ok[req_loc[i].lane]    = req_loc[i].word < 31'(DEPTH_WORDS);
      lane_word[req_loc[i].lane]  = AW'(req_loc[i].word);
      lane_wdata[req_loc[i].lane] = data_to_store[8*(LANES-1-i) +: 8];
    end
    req_err = |(lane_en & ~lane_ok);
  end

  assign lane_we = {LANES{accept &  is_store}} & lane_en & lane_ok;
  assign lane_re = {LANES{accept & ~is_store}} & lane_en & lane_ok;

  always_ff @(posedge CLOCK_50) begin : rsp_reg
    if (reset) begin
      rsp_valid  <= 1'b0;
      addr_error <= 1'b0;
      rsp_load   <= 1'b0;
      rsp_shift  <= 2'd0;
    end else begin
      rsp_valid  <= accept;
      addr_error <= accept & req_err;
      rsp_load   <= accept & ~is_store;
      rsp_shift  <= memory_address[1:0];
    end
  end

  // Undo the lane rotation: response byte i came from lane (address + i) mod 4.
  always_comb begin : load_assemble
    load_data = '0;
    for (int i = 0; i < LANES; i++) begin
      load_data[8*(LANES-1-i) +: 8] = rd_req[2'(rsp_shift + 2'(i))];
    end
  end

  assign writeback_register_data = rsp_load ? load_data : 32'h0;

  always_ff @(posedge CLOCK_50) begin : snoop_fsm
    if (reset) begin
      state       <= SNOOP_IDLE;
      ptr         <= '0;
      snoop_busy  <= 1'b0;
      snoop_valid <= 1'b0;
      snoop_index <= '0;
    end else begin
      snoop_valid <= (state == SNOOP_SCAN);
      case (state)
        SNOOP_IDLE: begin
          if (snoop_start) begin
            state      <= SNOOP_SCAN;
            snoop_busy <= 1'b1;
            ptr        <= '0;
          end
        end
        SNOOP_SCAN: begin
          snoop_index <= ptr;
          if (ptr == IDX_W'(SNOOP_BYTES - 1)) begin
            state      <= SNOOP_IDLE;
            snoop_busy <= 1'b0;
            ptr        <= '0;
          end else begin
            ptr <= ptr + IDX_W'(1);
          end
        end
        default: begin
          state      <= SNOOP_IDLE;
          snoop_busy <= 1'b0;
        end
      endcase
    end
  end

  assign snoop_loc  = byte_loc(32'(ptr), 2'd0);
  assign snoop_word = AW'(snoop_loc.word);

  always_comb begin : snoop_select
    snoop_re = '0;
    snoop_re[snoop_loc.lane] = (state == SNOOP_SCAN) && (snoop_loc.word < 31'(DEPTH_WORDS));
  end

  // Only the addressed lane reads; the others return zero, so OR-ing selects it.
  always_comb begin : snoop_collect
    snoop_mux = '0;
    for (int l = 0; l < LANES; l++) begin
      snoop_mux = snoop_mux | rd_snoop[l];
    end
  end

  assign snoop_byte = snoop_valid ? snoop_mux : 8'h00;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    byte_lane_ram #(
      .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
      .clk     (CLOCK_50),
      .we      (lane_we[l]),
      .waddr   (lane_word[l]),
      .wdata   (lane_wdata[l]),
      .re_a    (lane_re[l]),
      .raddr_a (lane_word[l]),
      .rdata_a (rd_req[l]),
      .re_b    (snoop_re[l]),
      .raddr_b (snoop_word),
      .rdata_b (rd_snoop[l])
    );
  end

endmodule

// File: tb/tb_byte_lane_memory.sv
// Self-checking bench for byte_lane_memory: directed vectors, snoop/reset
// sequences, and random requests against a byte-array reference model.
module tb_byte_lane_memory;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned SNOOP = 32;
  localparam int unsigned CAP   = 4 * DEPTH;
  localparam int unsigned IDX_W = $clog2(SNOOP);
  localparam int unsigned NVEC  = 23;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       code;
  logic [31:0]      addr;
  logic [31:0]      data;
  logic             rsp_valid;
  logic [31:0]      wb;
  logic             addr_error;
  logic             snoop_start;
  logic             busy;
  logic             svalid;
  logic [IDX_W-1:0] sidx;
  logic [7:0]       sbyte;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem_m [CAP];

  typedef struct {
    string       name;
    logic        st;
    logic [3:0]  be;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_wb;
    logic        exp_err;
  } vec_t;

  vec_t vecs [NVEC];

  byte_lane_memory #(.DEPTH_WORDS(DEPTH), .SNOOP_BYTES(SNOOP)) dut (
    .CLOCK_50                (clk),
    .reset                   (reset),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .memory_access_code      (code),
    .memory_address          (addr),
    .data_to_store           (data),
    .rsp_valid               (rsp_valid),
    .writeback_register_data (wb),
    .addr_error              (addr_error),
    .snoop_start             (snoop_start),
    .snoop_busy              (busy),
    .snoop_valid             (svalid),
    .snoop_index             (sidx),
    .snoop_byte              (sbyte)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-level reference: each enabled byte goes to address a+i, no wrap.
  function automatic void model(input logic st, input logic [3:0] be, input logic [31:0] a,
                                input logic [31:0] d, output logic [31:0] rd, output logic err);
    logic [33:0] b;
    rd  = '0;
    err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b = {2'b00, a} + 34'(i);
      if (be[3-i]) begin
        if (b >= 34'(CAP)) err = 1'b1;
        else if (st) mem_m[int'(b)] = d[31-8*i -: 8];
        else rd[31-8*i -: 8] = mem_m[int'(b)];
      end
    end
  endfunction

  task automatic do_req(input logic st, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    code      = {st, be};
    addr      = a;
    data      = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic model_req(input string name, input logic st, input logic [3:0] be,
                           input logic [31:0] a, input logic [31:0] d);
    logic [31:0] ew;
    logic        ee;
    model(st, be, a, d, ew, ee);
    do_req(st, be, a, d);
    check({name, "_valid"}, 32'(rsp_valid), 32'd1);
    check({name, "_data"}, wb, ew);
    check({name, "_err"}, 32'(addr_error), 32'(ee));
  endtask

  initial begin
    logic [31:0] ew;
    logic        ee;
    int got, cyc, ready_bad, late;
    logic stored5, hit;

    vecs[0]  = '{"st_aligned",   1'b1, 4'hF, 32'd0,        32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{"ld_aligned",   1'b0, 4'hF, 32'd0,        32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{"st_cross",     1'b1, 4'hF, 32'd6,        32'h11223344, 32'h0,        1'b0};
    vecs[3]  = '{"ld_cross4",    1'b0, 4'hF, 32'd4,        32'h0,        32'h00001122, 1'b0};
    vecs[4]  = '{"ld_cross8",    1'b0, 4'hF, 32'd8,        32'h0,        32'h33440000, 1'b0};
    vecs[5]  = '{"clr0",         1'b1, 4'hF, 32'd0,        32'h0,        32'h0,        1'b0};
    vecs[6]  = '{"clr4",         1'b1, 4'hF, 32'd4,        32'h0,        32'h0,        1'b0};
    vecs[7]  = '{"st_partial",   1'b1, 4'h5, 32'd1,        32'hAABBCCDD, 32'h0,        1'b0};
    vecs[8]  = '{"ld_partial1",  1'b0, 4'hF, 32'd1,        32'h0,        32'h00BB00DD, 1'b0};
    vecs[9]  = '{"ld_partial0",  1'b0, 4'hF, 32'd0,        32'h0,        32'h0000BB00, 1'b0};
    vecs[10] = '{"ld_partial4",  1'b0, 4'hF, 32'd4,        32'h0,        32'hDD000000, 1'b0};
    vecs[11] = '{"st_edge62",    1'b1, 4'hF, 32'd62,       32'h5A6B1234, 32'h0,        1'b1};
    vecs[12] = '{"ld_edge62",    1'b0, 4'hF, 32'd62,       32'h0,        32'h5A6B0000, 1'b1};
    vecs[13] = '{"ld_edge62_c",  1'b0, 4'hC, 32'd62,       32'h0,        32'h5A6B0000, 1'b0};
    vecs[14] = '{"st_oor64",     1'b1, 4'hF, 32'd64,       32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[15] = '{"ld_60",        1'b0, 4'hF, 32'd60,       32'h0,        32'h00005A6B, 1'b0};
    vecs[16] = '{"st_byte0",     1'b1, 4'h8, 32'd0,        32'h77000000, 32'h0,        1'b0};
    vecs[17] = '{"ld_wrap",      1'b0, 4'h3, 32'hFFFFFFFE, 32'h0,        32'h0,        1'b1};
    vecs[18] = '{"ld_alias256",  1'b0, 4'hF, 32'h100,      32'h0,        32'h0,        1'b1};
    vecs[19] = '{"ld_noalias0",  1'b0, 4'hF, 32'd0,        32'h0,        32'h7700BB00, 1'b0};
    vecs[20] = '{"ld_no_be",     1'b0, 4'h0, 32'd3,        32'h0,        32'h0,        1'b0};
    vecs[21] = '{"ld_last",      1'b0, 4'h8, 32'd63,       32'h0,        32'h6B000000, 1'b0};
    vecs[22] = '{"ld_past_last", 1'b0, 4'h4, 32'd63,       32'h0,        32'h0,        1'b1};

    reset = 1'b1; req_valid = 1'b0; code = '0; addr = '0; data = '0; snoop_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_addr_error", 32'(addr_error), 32'd0);
    check("rst_wb", wb, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_svalid", 32'(svalid), 32'd0);
    check("rst_sidx", 32'(sidx), 32'd0);
    check("rst_sbyte", 32'(sbyte), 32'd0);
    reset = 1'b0;
    #1;
    check("req_ready_up", 32'(req_ready), 32'd1);

    for (int w = 0; w < int'(DEPTH); w++) model_req("clear", 1'b1, 4'hF, 32'(4 * w), 32'h0);

    for (int v = 0; v < int'(NVEC); v++) begin
      model(vecs[v].st, vecs[v].be, vecs[v].a, vecs[v].d, ew, ee);
      do_req(vecs[v].st, vecs[v].be, vecs[v].a, vecs[v].d);
      check({vecs[v].name, "_valid"}, 32'(rsp_valid), 32'd1);
      check({vecs[v].name, "_data"}, wb, vecs[v].exp_wb);
      check({vecs[v].name, "_err"}, 32'(addr_error), 32'(vecs[v].exp_err));
    end

    for (int w = 0; w < 8; w++)
      model_req("fill", 1'b1, 4'hF, 32'(4 * w),
                {8'(4 * w), 8'(4 * w + 1), 8'(4 * w + 2), 8'(4 * w + 3)});

    // Scan with a store to byte 5 on the cycle the scan reads byte 5.
    snoop_start = 1'b1;
    got = 0; cyc = 0; ready_bad = 0; stored5 = 1'b0;
    while (got < int'(SNOOP) && cyc < 200) begin
      if (svalid && sidx == IDX_W'(4) && !stored5) begin
        model(1'b1, 4'h8, 32'd5, 32'hA5000000, ew, ee);
        req_valid = 1'b1; code = 5'h18; addr = 32'd5; data = 32'hA5000000;
        stored5 = 1'b1;
      end
      if (!req_ready) ready_bad++;
      @(posedge clk);
      #1;
      cyc++;
      req_valid = 1'b0;
      if (svalid) begin
        check("snoop_index", 32'(sidx), 32'(got));
        check("snoop_byte", 32'(sbyte), 32'(got));
        got++;
      end else if (got > 0) begin
        check("snoop_gap", 32'(svalid), 32'd1);
      end
    end
    check("snoop_count", 32'(got), 32'(SNOOP));
    check("snoop_ready", 32'(ready_bad), 32'd0);
    check("snoop_store5_done", 32'(stored5), 32'd1);
    check("busy_after_last", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_no_valid", 32'(svalid), 32'd0);
    snoop_start = 1'b0;

    hit = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(posedge clk);
      #1;
      if (svalid && sidx == IDX_W'(10)) hit = 1'b1;
    end
    check("reached_index10", 32'(hit), 32'd1);
    reset = 1'b1;
    req_valid = 1'b1; code = 5'h1F; addr = 32'd16; data = 32'hEEEEEEEE;
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_svalid", 32'(svalid), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_sidx", 32'(sidx), 32'd0);
    check("abort_sbyte", 32'(sbyte), 32'd0);
    reset = 1'b0;
    req_valid = 1'b0;
    late = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (svalid) late++;
    end
    check("no_late_svalid", 32'(late), 32'd0);
    model_req("intact16", 1'b0, 4'hF, 32'd16, 32'h0);
    model_req("intact4", 1'b0, 4'hF, 32'd4, 32'h0);
    model_req("intact0", 1'b0, 4'hF, 32'd0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, CAP + 4));
      model_req("rand", 1'(($urandom_range(0, 1))), 4'($urandom), ra, $urandom);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
